// File: rtl/accum_arbiter.sv
// -----------------------------------------------------------------------------
// accum_arbiter
//
// Round-robin arbiter and sequencer in front of the shared multi-cycle
// accumulator.  It picks one pending requester, captures that requester's
// value, and drives the accumulator's enable/value pins.  The value is held
// for the whole 3-cycle add sequence (ISSUE, WAIT1, WAIT2).  Operations can
// run back-to-back at one every 3 cycles.
//
// Ports
//   CLK           in   clock, rising edge
//   RST           in   synchronous active-high reset, priority over all state
//   req           in   [NREQ]        level request per requester
//   req_value     in   [NREQ*WIDTH]  requester i value on [i*WIDTH +: WIDTH]
//   ack           out  [NREQ]        one-cycle capture pulse for the winner
//   acc_enable    out  1             accumulator enable, one pulse per op
//   acc_value     out  [WIDTH]       accumulator value, held during the op
//   grant_id      out  [IDW]         requester currently being serviced
//   busy          out  1             operation in flight
//   issued_count  out  [CNTW]        operations issued, wraps
// -----------------------------------------------------------------------------
module accum_arbiter #(
   parameter  int NREQ  = 4,
   parameter  int WIDTH = 32,
   parameter  int CNTW  = 16,
   localparam int IDW   = $clog2(NREQ)
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] req_value,
   output logic [NREQ-1:0]       ack,
   output logic                  acc_enable,
   output logic [WIDTH-1:0]      acc_value,
   output logic [IDW-1:0]        grant_id,
   output logic                  busy,
   output logic [CNTW-1:0]       issued_count
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT1 = 2'd2,
      ST_WAIT2 = 2'd3
   } state_t;

   localparam logic [IDW-1:0]  LAST_RST = IDW'(NREQ - 1);
   localparam logic [CNTW-1:0] CNT_ONE  = {{(CNTW-1){1'b0}}, 1'b1};

   // One-hot decode of a requester index.
   function automatic logic [NREQ-1:0] onehot(input logic [IDW-1:0] id);
      logic [NREQ-1:0] vec;
      vec = {NREQ{1'b0}};
      for (int i = 0; i < NREQ; i++) begin
         if (IDW'(i) == id) begin
            vec[i] = 1'b1;
         end else begin
            vec[i] = 1'b0;
         end
      end
      return vec;
   endfunction

   state_t            state_r;
   state_t            state_nxt_s;
   logic [IDW-1:0]    last_r;
   logic [NREQ-1:0]   ack_r;
   logic              acc_enable_r;
   logic [WIDTH-1:0]  acc_value_r;
   logic [IDW-1:0]    grant_id_r;
   logic              busy_r;
   logic [CNTW-1:0]   issued_count_r;

   logic              win_found_s;
   logic [IDW-1:0]    win_id_s;
   logic [IDW-1:0]    idx_s;
   logic              take_s;

   logic [NREQ-1:0]   ack_nxt_s;
   logic              acc_enable_nxt_s;
   logic [WIDTH-1:0]  acc_value_nxt_s;
   logic [IDW-1:0]    grant_id_nxt_s;
   logic              busy_nxt_s;
   logic [IDW-1:0]    last_nxt_s;
   logic [CNTW-1:0]   issued_count_nxt_s;

   // Round-robin search: first pending index starting just after the last winner.
   always_comb begin
      win_found_s = 1'b0;
      win_id_s    = {IDW{1'b0}};
      idx_s       = {IDW{1'b0}};
      for (int k = 1; k <= NREQ; k++) begin
         idx_s = IDW'((int'(last_r) + k) % NREQ);
         if (!win_found_s && req[idx_s]) begin
            win_found_s = 1'b1;
            win_id_s    = idx_s;
         end else begin
            win_found_s = win_found_s;
         end
      end
   end

   // State register.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic; req is only looked at in IDLE and WAIT2.
   always_comb begin
      state_nxt_s = state_r;
      take_s      = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (win_found_s) begin
               take_s      = 1'b1;
               state_nxt_s = ST_ISSUE;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            state_nxt_s = ST_WAIT1;
         end
         ST_WAIT1: begin
            state_nxt_s = ST_WAIT2;
         end
         ST_WAIT2: begin
            if (win_found_s) begin
               take_s      = 1'b1;
               state_nxt_s = ST_ISSUE;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Output logic: next values of the registered outputs, decoded from the
   // state being entered so the pins line up with the state itself.
   always_comb begin
      acc_enable_nxt_s = 1'b0;
      busy_nxt_s       = 1'b0;
      case (state_nxt_s)
         ST_IDLE: begin
            acc_enable_nxt_s = 1'b0;
            busy_nxt_s       = 1'b0;
         end
         ST_ISSUE: begin
            acc_enable_nxt_s = 1'b1;
            busy_nxt_s       = 1'b1;
         end
         ST_WAIT1, ST_WAIT2: begin
            acc_enable_nxt_s = 1'b0;
            busy_nxt_s       = 1'b1;
         end
         default: begin
            acc_enable_nxt_s = 1'b0;
            busy_nxt_s       = 1'b0;
         end
      endcase

      if (take_s) begin
         ack_nxt_s          = onehot(win_id_s);
         acc_value_nxt_s    = req_value[int'(win_id_s)*WIDTH +: WIDTH];
         grant_id_nxt_s     = win_id_s;
         last_nxt_s         = win_id_s;
         issued_count_nxt_s = issued_count_r + CNT_ONE;
      end else begin
         ack_nxt_s          = {NREQ{1'b0}};
         acc_value_nxt_s    = acc_value_r;
         grant_id_nxt_s     = grant_id_r;
         last_nxt_s         = last_r;
         issued_count_nxt_s = issued_count_r;
      end
   end

   // Output and bookkeeping registers.
   always_ff @(posedge CLK) begin
      if (RST) begin
         ack_r          <= {NREQ{1'b0}};
         acc_enable_r   <= 1'b0;
         acc_value_r    <= {WIDTH{1'b0}};
         grant_id_r     <= {IDW{1'b0}};
         busy_r         <= 1'b0;
         last_r         <= LAST_RST;
         issued_count_r <= {CNTW{1'b0}};
      end else begin
         ack_r          <= ack_nxt_s;
         acc_enable_r   <= acc_enable_nxt_s;
         acc_value_r    <= acc_value_nxt_s;
         grant_id_r     <= grant_id_nxt_s;
         busy_r         <= busy_nxt_s;
         last_r         <= last_nxt_s;
         issued_count_r <= issued_count_nxt_s;
      end
   end

   assign ack          = ack_r;
   assign acc_enable   = acc_enable_r;
   assign acc_value    = acc_value_r;
   assign grant_id     = grant_id_r;
   assign busy         = busy_r;
   assign issued_count = issued_count_r;

   accum_arbiter_checker #(
      .NREQ (NREQ)
   ) u_checker (
      .CLK        (CLK),
      .RST        (RST),
      .ack        (ack_r),
      .acc_enable (acc_enable_r)
   );

endmodule

// -----------------------------------------------------------------------------
// accum_arbiter_checker
//
// Protocol properties of the arbiter outputs: ack and acc_enable coincide,
// at most one ack bit is set, and enable pulses are at least 3 cycles apart.
//
// Ports
//   CLK, RST     clock and synchronous reset shared with the arbiter
//   ack          [NREQ] arbiter ack outputs
//   acc_enable   arbiter accumulator enable
// -----------------------------------------------------------------------------
module accum_arbiter_checker #(
   parameter int NREQ = 4
) (
   input logic            CLK,
   input logic            RST,
   input logic [NREQ-1:0] ack,
   input logic            acc_enable
);

   logic en_d1_r;
   logic en_d2_r;

   // Enable history and per-cycle protocol checks.
   always_ff @(posedge CLK) begin
      if (RST) begin
         en_d1_r <= 1'b0;
         en_d2_r <= 1'b0;
      end else begin
         en_d1_r <= acc_enable;
         en_d2_r <= en_d1_r;
         assert ((|ack) == acc_enable);
         assert ($onehot0(ack));
         assert (!(acc_enable && (en_d1_r || en_d2_r)));
      end
   end

endmodule

// File: tb/tb_accum_arbiter.sv
module tb_accum_arbiter;

   localparam int NREQ  = 4;
   localparam int WIDTH = 32;

   logic                  CLK;
   logic                  RST;
   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] req_value;
   logic [NREQ-1:0]       ack;
   logic                  acc_enable;
   logic [WIDTH-1:0]      acc_value;
   logic [1:0]            grant_id;
   logic                  busy;
   logic [15:0]           issued_count;

   logic [NREQ-1:0]       req_w;
   logic [NREQ*WIDTH-1:0] req_value_w;
   logic [NREQ-1:0]       ack_w;
   logic                  acc_enable_w;
   logic [WIDTH-1:0]      acc_value_w;
   logic [1:0]            grant_id_w;
   logic                  busy_w;
   logic [3:0]            issued_count_w;

   int checks = 0;
   int errors = 0;

   // accumulator model: enable seen in cycle 1, adds at end of cycle 3
   logic             en_d1;
   logic             en_d2;
   logic [WIDTH-1:0] total;

   accum_arbiter dut (
      .CLK          (CLK),
      .RST          (RST),
      .req          (req),
      .req_value    (req_value),
      .ack          (ack),
      .acc_enable   (acc_enable),
      .acc_value    (acc_value),
      .grant_id     (grant_id),
      .busy         (busy),
      .issued_count (issued_count)
   );

   accum_arbiter #(.CNTW(4)) dut_w (
      .CLK          (CLK),
      .RST          (RST),
      .req          (req_w),
      .req_value    (req_value_w),
      .ack          (ack_w),
      .acc_enable   (acc_enable_w),
      .acc_value    (acc_value_w),
      .grant_id     (grant_id_w),
      .busy         (busy_w),
      .issued_count (issued_count_w)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   always @(posedge CLK) begin
      if (RST) begin
         en_d1 <= 1'b0;
         en_d2 <= 1'b0;
         total <= '0;
      end else begin
         en_d1 <= acc_enable;
         en_d2 <= en_d1;
         if (en_d2) total <= total + acc_value;
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic setv(input int i, input logic [WIDTH-1:0] v);
      req_value[i*WIDTH +: WIDTH] = v;
   endtask

   initial begin
      RST = 1'b1;
      req = '0;
      req_value = '0;
      req_w = '0;
      req_value_w = '0;

      // reset state
      tick();
      chk("rst_ack", ack, 4'b0000);
      chk("rst_en", acc_enable, 1'b0);
      chk("rst_value", acc_value, 32'd0);
      chk("rst_grant", grant_id, 2'd0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_count", issued_count, 16'd0);
      tick();
      RST = 1'b0;

      // single request from requester 2
      setv(2, 32'd5);
      req = 4'b0100;
      tick();
      chk("single_ack", ack, 4'b0100);
      chk("single_en", acc_enable, 1'b1);
      chk("single_value_c1", acc_value, 32'd5);
      chk("single_busy_c1", busy, 1'b1);
      chk("single_grant", grant_id, 2'd2);
      chk("single_count", issued_count, 16'd1);
      req = 4'b0000;
      tick();
      chk("single_ack_c2", ack, 4'b0000);
      chk("single_en_c2", acc_enable, 1'b0);
      chk("single_value_c2", acc_value, 32'd5);
      chk("single_busy_c2", busy, 1'b1);
      tick();
      chk("single_value_c3", acc_value, 32'd5);
      chk("single_busy_c3", busy, 1'b1);
      tick();
      chk("single_total", total, 32'd5);
      chk("single_idle", busy, 1'b0);
      chk("single_en_c4", acc_enable, 1'b0);

      // saturation, starting from a fresh reset so requester 0 is first
      RST = 1'b1;
      tick();
      RST = 1'b0;
      setv(0, 32'd1);
      setv(1, 32'd2);
      setv(2, 32'd3);
      setv(3, 32'd4);
      req = 4'b1111;
      tick();
      for (int k = 0; k < 4; k++) begin
         chk("sat_ack", ack, 4'b0001 << k);
         chk("sat_en", acc_enable, 1'b1);
         chk("sat_grant", grant_id, k);
         chk("sat_value", acc_value, k + 1);
         if (k == 3) req = 4'b0000;
         tick();
         chk("sat_gap1_en", acc_enable, 1'b0);
         chk("sat_gap1_ack", ack, 4'b0000);
         tick();
         chk("sat_gap2_en", acc_enable, 1'b0);
         chk("sat_gap2_busy", busy, 1'b1);
         tick();
      end
      chk("sat_total", total, 32'd10);
      chk("sat_idle", busy, 1'b0);
      chk("sat_count", issued_count, 16'd4);

      // fairness after a grant to 1: 3 before 0
      req = 4'b0010;
      tick();
      chk("fair1_grant1", grant_id, 2'd1);
      req = 4'b1001;
      tick();
      tick();
      tick();
      chk("fair1_first", grant_id, 2'd3);
      chk("fair1_first_ack", ack, 4'b1000);
      req = 4'b0001;
      tick();
      tick();
      tick();
      chk("fair1_second", grant_id, 2'd0);
      chk("fair1_second_ack", ack, 4'b0001);
      req = 4'b0000;
      tick();
      tick();
      tick();
      chk("fair1_idle", busy, 1'b0);

      // fairness after a grant to 3: 0 before 1
      req = 4'b1000;
      tick();
      chk("fair2_grant3", grant_id, 2'd3);
      req = 4'b0011;
      tick();
      tick();
      tick();
      chk("fair2_first", grant_id, 2'd0);
      req = 4'b0010;
      tick();
      tick();
      tick();
      chk("fair2_second", grant_id, 2'd1);
      req = 4'b0000;
      tick();
      tick();
      tick();
      chk("fair2_idle", busy, 1'b0);

      // capture isolation
      RST = 1'b1;
      tick();
      RST = 1'b0;
      setv(1, 32'd7);
      req = 4'b0010;
      tick();
      chk("iso_ack", ack, 4'b0010);
      chk("iso_value_c1", acc_value, 32'd7);
      setv(1, 32'd99);
      req = 4'b0000;
      tick();
      chk("iso_value_c2", acc_value, 32'd7);
      tick();
      chk("iso_value_c3", acc_value, 32'd7);
      tick();
      chk("iso_total", total, 32'd7);
      chk("iso_value_c4", acc_value, 32'd7);

      // reset in WAIT1
      req = 4'b1111;
      tick();
      chk("mid_grant", grant_id, 2'd2);
      tick();
      chk("mid_wait1_busy", busy, 1'b1);
      RST = 1'b1;
      tick();
      chk("mid_busy", busy, 1'b0);
      chk("mid_en", acc_enable, 1'b0);
      chk("mid_ack", ack, 4'b0000);
      chk("mid_value", acc_value, 32'd0);
      chk("mid_count", issued_count, 16'd0);
      RST = 1'b0;
      tick();
      chk("post_rst_ack", ack, 4'b0001);
      chk("post_rst_grant", grant_id, 2'd0);
      req = 4'b0000;
      tick();
      tick();
      tick();
      chk("post_rst_idle", busy, 1'b0);

      // counter wrap on the CNTW=4 instance
      req_value_w[WIDTH-1:0] = 32'd3;
      req_w = 4'b0001;
      tick();
      for (int n = 1; n <= 16; n++) begin
         chk("wrap_en", acc_enable_w, 1'b1);
         chk("wrap_count", issued_count_w, n % 16);
         if (n == 16) req_w = 4'b0000;
         tick();
         tick();
         tick();
      end
      chk("wrap_idle", busy_w, 1'b0);
      chk("wrap_hold", issued_count_w, 4'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
